// File: rtl/ppu_pads_pkg.sv
`default_nettype none
// ============================================================================
// Package   : ppu_pads_pkg
// Purpose   : Shared types and helpers for the PPU VRAM bus sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
package ppu_pads_pkg;

   // Bus cycle phases, in the order a single access walks through them
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ALE  = 3'd1,
      HOLD = 3'd2,
      STB  = 3'd3,
      REC  = 3'd4
   } bus_state_t;

   // Width of the phase down-counter: it must hold (longest phase - 1)
   function automatic int phase_cnt_w(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage : ppu_pads_pkg
`default_nettype wire

// File: rtl/ppu_vram_bus_seq.sv
`default_nettype none
// ============================================================================
// Module    : ppu_vram_bus_seq
// Purpose   : Sequences one multiplexed VRAM address/data bus cycle per
//             request: ALE phase, address hold, /RD or /WR strobe, optional
//             recovery. All pad outputs are registered; read data is latched.
// Revision  : 1.0 - initial release
// ============================================================================
module ppu_vram_bus_seq
   import ppu_pads_pkg::*;
#(
   parameter int AW       = 14,
   parameter int DW       = 8,
   parameter int ALE_CYC  = 1,
   parameter int HOLD_CYC = 1,
   parameter int STB_CYC  = 2,
   parameter int REC_CYC  = 1
) (
   input  logic               PCLK,
   input  logic               RES,
   input  logic               req,
   input  logic               we,
   input  logic [AW-1:0]      addr,
   input  logic [DW-1:0]      wdata,
   output logic               ack,
   output logic [DW-1:0]      rdata,
   output logic               busy,
   output logic [DW-1:0]      ad_out,
   output logic               ad_oe,
   input  logic [DW-1:0]      ad_in,
   output logic [AW-DW-1:0]   pa_out,
   output logic               ale,
   output logic               n_rd,
   output logic               n_wr
);

   localparam int CNT_W = phase_cnt_w(ALE_CYC, HOLD_CYC, STB_CYC, REC_CYC);

   // Counter load values: a phase of N cycles counts N-1 down to 0
   localparam logic [CNT_W-1:0] LD_ALE  = CNT_W'(ALE_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_STB  = CNT_W'(STB_CYC - 1);
   localparam logic [CNT_W-1:0] LD_REC  = CNT_W'((REC_CYC > 0) ? REC_CYC - 1 : 0);
   localparam logic             HAS_REC = (REC_CYC > 0);

   bus_state_t        state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              we_q,     we_d;
   logic [DW-1:0]     wdata_q,  wdata_d;
   logic [DW-1:0]     rdata_q,  rdata_d;
   logic              ack_q,    ack_d;
   logic              busy_q,   busy_d;
   logic              ale_q,    ale_d;
   logic              n_rd_q,   n_rd_d;
   logic              n_wr_q,   n_wr_d;
   logic              ad_oe_q,  ad_oe_d;
   logic [DW-1:0]     ad_out_q, ad_out_d;
   logic [AW-DW-1:0]  pa_out_q, pa_out_d;

   // Phase sequencing; pad values are computed for the state being entered
   // so every pad comes straight from a flop
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ack_d    = 1'b0;
      ale_d    = ale_q;
      n_rd_d   = n_rd_q;
      n_wr_d   = n_wr_q;
      ad_oe_d  = ad_oe_q;
      ad_out_d = ad_out_q;
      pa_out_d = pa_out_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               // Capture the whole request; the address lives on in the
               // AD/PA registers for the rest of the access
               we_d     = we;
               wdata_d  = wdata;
               state_d  = ALE;
               cnt_d    = LD_ALE;
               ale_d    = 1'b1;
               ad_oe_d  = 1'b1;
               ad_out_d = addr[DW-1:0];
               pa_out_d = addr[AW-1:DW];
            end
         end

         ALE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = LD_HOLD;
               ale_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         HOLD: begin
            if (cnt_q == '0) begin
               state_d = STB;
               cnt_d   = LD_STB;
               if (we_q) begin
                  // AD switches from address to data together with /WR
                  n_wr_d   = 1'b0;
                  ad_oe_d  = 1'b1;
                  ad_out_d = wdata_q;
               end else begin
                  // Release AD before the memory starts driving it
                  n_rd_d  = 1'b0;
                  ad_oe_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         STB: begin
            if (cnt_q == '0) begin
               // Last strobe cycle: latch read data so it is valid with ack
               if (!we_q) begin
                  rdata_d = ad_in;
               end
               ack_d   = 1'b1;
               n_rd_d  = 1'b1;
               n_wr_d  = 1'b1;
               ad_oe_d = 1'b0;
               if (HAS_REC) begin
                  state_d = REC;
                  cnt_d   = LD_REC;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         REC: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            n_rd_d  = 1'b1;
            n_wr_d  = 1'b1;
            ale_d   = 1'b0;
            ad_oe_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and pad registers; reset drops strobes and tristates AD at once
   always_ff @(posedge PCLK or posedge RES) begin
      if (RES) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         ale_q    <= 1'b0;
         n_rd_q   <= 1'b1;
         n_wr_q   <= 1'b1;
         ad_oe_q  <= 1'b0;
         ad_out_q <= '0;
         pa_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         ale_q    <= ale_d;
         n_rd_q   <= n_rd_d;
         n_wr_q   <= n_wr_d;
         ad_oe_q  <= ad_oe_d;
         ad_out_q <= ad_out_d;
         pa_out_q <= pa_out_d;
      end
   end

   assign ack    = ack_q;
   assign rdata  = rdata_q;
   assign busy   = busy_q;
   assign ale    = ale_q;
   assign n_rd   = n_rd_q;
   assign n_wr   = n_wr_q;
   assign ad_oe  = ad_oe_q;
   assign ad_out = ad_out_q;
   assign pa_out = pa_out_q;

endmodule : ppu_vram_bus_seq
`default_nettype wire

// File: tb/tb_ppu_vram_bus_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_ppu_vram_bus_seq
// Purpose   : Scoreboard bench for the VRAM bus sequencer, run on the default
//             phase timing and on ALE=2/HOLD=3/STB=1/REC=0 side by side.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_bus_seq;

   logic PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;

   // One accepted access: edge index at which IDLE samples it, plus payload
   typedef struct {
      int          a;
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wdata;
   } tx_t;

   // One stimulus item: idle gap before it, and optional fixed ad_in value
   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wdata;
      int          gap;
      logic        fen;
      logic [7:0]  fval;
   } stim_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int A = (g == 0) ? 1 : 2;
      localparam int H = (g == 0) ? 1 : 3;
      localparam int S = (g == 0) ? 2 : 1;
      localparam int R = (g == 0) ? 1 : 0;
      localparam int P = A + H + S + R + 1;

      logic        res   = 1'b1;
      logic        req   = 1'b0;
      logic        we    = 1'b0;
      logic [13:0] addr  = '0;
      logic [7:0]  wdata = '0;
      logic [7:0]  ad_in = '0;
      logic        ack, busy, ad_oe, ale, n_rd, n_wr;
      logic [7:0]  rdata, ad_out;
      logic [5:0]  pa_out;

      ppu_vram_bus_seq #(
         .AW(14), .DW(8), .ALE_CYC(A), .HOLD_CYC(H), .STB_CYC(S), .REC_CYC(R)
      ) u_dut (
         .PCLK(PCLK), .RES(res), .req(req), .we(we), .addr(addr), .wdata(wdata),
         .ack(ack), .rdata(rdata), .busy(busy), .ad_out(ad_out), .ad_oe(ad_oe),
         .ad_in(ad_in), .pa_out(pa_out), .ale(ale), .n_rd(n_rd), .n_wr(n_wr)
      );

      int          cyc   = 0;
      int          nf    = 0;
      logic        fin   = 1'b0;
      logic        fen   = 1'b0;
      logic [7:0]  fval  = 8'h00;
      logic [7:0]  m_rdata = 8'h00;
      logic [7:0]  hist [int];
      tx_t         sbq [$];

      // Edge counter and ad_in history (value present at each rising edge)
      always @(posedge PCLK) begin
         cyc = cyc + 1;
         hist[cyc] = ad_in;
         #1 ad_in = fen ? fval : 8'($urandom);
      end

      // Monitor: per-cycle pad check against the head access of the scoreboard
      always @(negedge PCLK) begin
         logic       e_ale, e_rd, e_wr, e_oe, e_busy, e_ack, c_ad, c_pa;
         logic [7:0] e_ad;
         logic [5:0] e_pa;
         int         o;
         tx_t        t;
         check($sformatf("g%0d_inv_rd_wr", g), 32'(!n_rd && !n_wr), 0);
         check($sformatf("g%0d_inv_ale_stb", g), 32'(ale && (!n_rd || !n_wr)), 0);
         check($sformatf("g%0d_inv_rd_oe", g), 32'(!n_rd && ad_oe), 0);
         if (res) begin
            check($sformatf("g%0d_rst_outs", g),
                  32'({ack, busy, ale, n_rd, n_wr, ad_oe, ad_out, pa_out, rdata}),
                  32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 6'h00, 8'h00}));
            sbq.delete();
            m_rdata = 8'h00;
         end else begin
            e_ale = 1'b0; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0;
            e_busy = 1'b0; e_ack = 1'b0; c_ad = 1'b0; c_pa = 1'b0;
            e_ad = 8'h00; e_pa = 6'h00; o = -1;
            if (sbq.size() > 0 && cyc >= sbq[0].a) begin
               t      = sbq[0];
               o      = cyc - t.a;
               e_busy = (o < A + H + S + R);
               e_ack  = (o == A + H + S);
               c_pa   = (o < A + H + S + R);
               e_pa   = t.addr[13:8];
               if (o < A) begin
                  e_ale = 1'b1; e_oe = 1'b1; c_ad = 1'b1; e_ad = t.addr[7:0];
               end else if (o < A + H) begin
                  e_oe = 1'b1; c_ad = 1'b1; e_ad = t.addr[7:0];
               end else if (o < A + H + S) begin
                  if (t.we) begin
                     e_wr = 1'b0; e_oe = 1'b1; c_ad = 1'b1; e_ad = t.wdata;
                  end else begin
                     e_rd = 1'b0;
                  end
               end
               if (e_ack && !t.we) m_rdata = hist[t.a + A + H + S];
            end
            check($sformatf("g%0d_ack", g),   32'(ack),   32'(e_ack));
            check($sformatf("g%0d_busy", g),  32'(busy),  32'(e_busy));
            check($sformatf("g%0d_ale", g),   32'(ale),   32'(e_ale));
            check($sformatf("g%0d_n_rd", g),  32'(n_rd),  32'(e_rd));
            check($sformatf("g%0d_n_wr", g),  32'(n_wr),  32'(e_wr));
            check($sformatf("g%0d_ad_oe", g), 32'(ad_oe), 32'(e_oe));
            check($sformatf("g%0d_rdata", g), 32'(rdata), 32'(m_rdata));
            if (c_ad) check($sformatf("g%0d_ad_out", g), 32'(ad_out), 32'(e_ad));
            if (c_pa) check($sformatf("g%0d_pa_out", g), 32'(pa_out), 32'(e_pa));
            if (o == P - 1) t = sbq.pop_front();
         end
      end

      // Driver: reset-abort test, directed accesses, then randomized traffic
      initial begin
         stim_t st [$];
         stim_t s;
         tx_t   t;
         repeat (2) @(posedge PCLK);
         #1;
         res = 1'b0;
         nf  = cyc + 1;

         // Read aborted by reset in its 2nd strobe cycle (only one if STB=1)
         fval = 8'hA5; fen = 1'b1;
         req = 1'b1; we = 1'b0; addr = 14'h1555; wdata = 8'h00;
         t.a = cyc + 1; t.we = 1'b0; t.addr = addr; t.wdata = 8'h00;
         sbq.push_back(t);
         while (cyc < t.a + A + H + ((S > 1) ? 1 : 0)) begin @(posedge PCLK); #1; end
         #1;
         check($sformatf("g%0d_pre_rst_n_rd", g), 32'(n_rd), 0);
         res = 1'b1; req = 1'b0; fen = 1'b0;
         #1;
         check($sformatf("g%0d_abort_n_rd", g),  32'(n_rd),  1);
         check($sformatf("g%0d_abort_ad_oe", g), 32'(ad_oe), 0);
         check($sformatf("g%0d_abort_busy", g),  32'(busy),  0);
         check($sformatf("g%0d_abort_ack", g),   32'(ack),   0);
         check($sformatf("g%0d_abort_rdata", g), 32'(rdata), 0);
         @(posedge PCLK); @(posedge PCLK);
         #1;
         res = 1'b0;
         nf  = cyc + 1;
         repeat (3) begin @(posedge PCLK); #1; end

         s = '{we:1'b1, addr:14'h2ABC, wdata:8'h5A, gap:0, fen:1'b0, fval:8'h00};
         st.push_back(s);
         s = '{we:1'b0, addr:14'h3F00, wdata:8'h00, gap:1, fen:1'b1, fval:8'hC3};
         st.push_back(s);
         s = '{we:1'b1, addr:14'h0155, wdata:8'h66, gap:0, fen:1'b0, fval:8'h00};
         st.push_back(s);
         for (int i = 0; i < 28; i++) begin
            s.we    = 1'($urandom);
            s.addr  = 14'($urandom);
            s.wdata = 8'($urandom);
            s.gap   = (i < 4) ? 0 : int'($urandom_range(0, 2));
            s.fen   = 1'b0;
            s.fval  = 8'h00;
            st.push_back(s);
         end

         foreach (st[i]) begin
            s   = st[i];
            req = 1'b0;
            repeat (s.gap) begin @(posedge PCLK); #1; end
            fen = s.fen; fval = s.fval;
            req = 1'b1; we = s.we; addr = s.addr; wdata = s.wdata;
            t.a     = (cyc + 1 > nf) ? cyc + 1 : nf;
            t.we    = s.we;
            t.addr  = s.addr;
            t.wdata = s.wdata;
            sbq.push_back(t);
            nf = t.a + P;
            while (cyc < t.a) begin @(posedge PCLK); #1; end
            // Inputs wander while the access is in flight; only req stays up
            we = 1'($urandom); addr = 14'($urandom); wdata = 8'($urandom);
            while (cyc < t.a + A + H + S) begin @(posedge PCLK); #1; end
            fen = 1'b0;
         end
         req = 1'b0;
         repeat (P + 2) begin @(posedge PCLK); #1; end
         check($sformatf("g%0d_sb_empty", g), 32'(sbq.size()), 0);
         fin = 1'b1;
      end
   end

   initial begin
      int waited;
      waited = 0;
      while (!(g_dut[0].fin && g_dut[1].fin) && waited < 20000) begin
         @(posedge PCLK);
         waited++;
      end
      if (waited >= 20000) begin
         total++;
         bad++;
         $display("FAIL timeout: got %0d cycles without completion, required < 20000", waited);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ppu_vram_bus_seq
`default_nettype wire
